// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode-to-ALU operand stage handshake and data bus.
interface alu_operand_stage_if #(
    parameter int WIDTH = 16,
    parameter int IMM_W = 6
);
    logic             en;
    logic             valid_in;
    logic [3:0]       srcx;
    logic [WIDTH-1:0] reg_dout;
    logic [IMM_W-1:0] imm;
    logic             prefix_load;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             prefix_pending;
    logic             src_err;

    modport master (
        output en, valid_in, srcx, reg_dout, imm, prefix_load,
        input  dout, dout_valid, prefix_pending, src_err
    );

    modport slave (
        input  en, valid_in, srcx, reg_dout, imm, prefix_load,
        output dout, dout_valid, prefix_pending, src_err
    );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered ALU operand select with immediate extension and prefix literal accumulation.
module alu_operand_stage #(
    parameter int WIDTH      = 16,
    parameter int IMM_W      = 6,
    parameter int PREFIX_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_operand_stage_if.slave  bus
);
    localparam int CW = $clog2(PREFIX_MAX + 1);

    logic [WIDTH-1:0] sext, zext, acc_shift, op_d;
    logic [WIDTH-1:0] dout_q, acc_q;
    logic [CW-1:0]    cnt_q;
    logic             dout_valid_q, pend_q, err_q;
    logic             illegal;

    assign sext      = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    assign zext      = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
    assign acc_shift = (acc_q << IMM_W) | zext;
    assign illegal   = bus.srcx >= 4'd12;

    // HOLD reuses dout_q: DOUT only changes when a valid operand is issued
    always_comb begin
        op_d = '0;
        case (bus.srcx)
            4'd0:    op_d = bus.reg_dout;
            4'd2:    op_d = WIDTH'(1);
            4'd3:    op_d = WIDTH'(2);
            4'd4:    op_d = '1;
            4'd5:    op_d = ~WIDTH'(1);
            4'd6:    op_d = sext;
            4'd7:    op_d = sext << 1;
            4'd8:    op_d = sext << 2;
            4'd9:    op_d = zext;
            4'd10:   op_d = acc_shift;
            4'd11:   op_d = dout_q;
            default: op_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (bus.en) begin
            dout_valid_q <= bus.valid_in & ~bus.prefix_load;
            if (bus.valid_in && bus.prefix_load) begin
                acc_q  <= acc_shift;
                cnt_q  <= (cnt_q == CW'(PREFIX_MAX)) ? cnt_q : cnt_q + 1'b1;
                pend_q <= 1'b1;
            end else if (bus.valid_in) begin
                dout_q <= op_d;
                acc_q  <= '0;
                cnt_q  <= '0;
                pend_q <= 1'b0;
                if (illegal) err_q <= 1'b1;
            end
        end
    end

    assign bus.dout           = dout_q;
    assign bus.dout_valid     = dout_valid_q;
    assign bus.prefix_pending = pend_q;
    assign bus.src_err        = err_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and randomized checks against an arithmetic reference model.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    int m_acc, m_dout;
    bit m_valid, m_pend, m_err;

    alu_operand_stage_if #(.WIDTH(16), .IMM_W(6)) bus ();

    alu_operand_stage #(.WIDTH(16), .IMM_W(6), .PREFIX_MAX(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int wrap(int x);
        return ((x % 65536) + 65536) % 65536;
    endfunction

    function automatic int model_op(int s, int r, int imm);
        int sv = (imm >= 32) ? imm - 64 : imm;
        case (s)
            0: return r;
            1: return 0;
            2: return 1;
            3: return 2;
            4: return 65535;
            5: return 65534;
            6: return wrap(sv);
            7: return wrap(sv * 2);
            8: return wrap(sv * 4);
            9: return imm;
            10: return wrap(m_acc * 64 + imm);
            11: return m_dout;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_acc = 0; m_dout = 0; m_valid = 0; m_pend = 0; m_err = 0;
    endtask

    task automatic drive(bit en, bit v, int s, int r, int imm, bit pl);
        bus.en = en; bus.valid_in = v; bus.srcx = 4'(s);
        bus.reg_dout = 16'(r); bus.imm = 6'(imm); bus.prefix_load = pl;
        if (en) begin
            if (v && pl) begin
                m_acc = wrap(m_acc * 64 + imm);
                m_pend = 1;
            end else if (v) begin
                m_dout = model_op(s, r, imm);
                m_acc = 0;
                m_pend = 0;
                if (s >= 12) m_err = 1;
            end
            m_valid = v && !pl;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.en = 1; bus.valid_in = 0; bus.srcx = 0; bus.reg_dout = 0; bus.imm = 0; bus.prefix_load = 0;
        model_reset();
        rst_n = 0;
        #2;
        checks++;
        if ({bus.dout, bus.dout_valid, bus.prefix_pending, bus.src_err} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state got dout=%h v=%b p=%b e=%b want all 0", bus.dout, bus.dout_valid, bus.prefix_pending, bus.src_err);
        end
        rst_n = 1;
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_bubble got v=%b want 0", bus.dout_valid);
        end
    endtask

    task automatic test_constants();
        int srcs[5] = '{4, 5, 6, 8, 9};
        int imms[5] = '{0, 0, 33, 33, 33};
        logic [15:0] want[5] = '{16'hFFFF, 16'hFFFE, 16'hFFE1, 16'hFF84, 16'h0021};
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, srcs[i], 0, imms[i], 0);
            checks++;
            if (bus.dout !== want[i] || bus.dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL const_src%0d got dout=%h v=%b want %h v=1", srcs[i], bus.dout, bus.dout_valid, want[i]);
            end
        end
    endtask

    task automatic test_prefix_chain();
        drive(1, 1, 0, 0, 6'h3F, 1);
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.prefix_pending !== 1'b1) begin
            errors++;
            $display("FAIL prefix1 got v=%b p=%b want v=0 p=1", bus.dout_valid, bus.prefix_pending);
        end
        drive(1, 1, 7, 0, 6'h00, 1);
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.prefix_pending !== 1'b1) begin
            errors++;
            $display("FAIL prefix2 got v=%b p=%b want v=0 p=1", bus.dout_valid, bus.prefix_pending);
        end
        drive(1, 1, 10, 0, 6'h15, 0);
        checks++;
        if (bus.dout !== 16'hF015 || bus.dout_valid !== 1'b1 || bus.prefix_pending !== 1'b0) begin
            errors++;
            $display("FAIL prefixed got dout=%h v=%b p=%b want F015 v=1 p=0", bus.dout, bus.dout_valid, bus.prefix_pending);
        end
    endtask

    task automatic test_stall();
        logic [15:0] d0;
        logic v0, p0;
        drive(1, 1, 0, 0, 6'h3F, 1);
        d0 = bus.dout; v0 = bus.dout_valid; p0 = bus.prefix_pending;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, $urandom_range(15), $urandom, $urandom_range(63), $urandom_range(1));
            checks++;
            if (bus.dout !== d0 || bus.dout_valid !== v0 || bus.prefix_pending !== p0) begin
                errors++;
                $display("FAIL stall%0d got dout=%h v=%b p=%b want %h v=%b p=%b", i, bus.dout, bus.dout_valid, bus.prefix_pending, d0, v0, p0);
            end
        end
        drive(1, 1, 0, 0, 6'h00, 1);
        drive(1, 1, 10, 0, 6'h15, 0);
        checks++;
        if (bus.dout !== 16'hF015 || bus.prefix_pending !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume got dout=%h p=%b want F015 p=0", bus.dout, bus.prefix_pending);
        end
    endtask

    task automatic test_prefix_discard();
        drive(1, 1, 0, 0, 6'h2A, 1);
        drive(1, 1, 0, 16'h1234, 6'h11, 0);
        checks++;
        if (bus.dout !== 16'h1234 || bus.prefix_pending !== 1'b0) begin
            errors++;
            $display("FAIL discard_reg got dout=%h p=%b want 1234 p=0", bus.dout, bus.prefix_pending);
        end
        drive(1, 1, 10, 0, 6'h01, 0);
        checks++;
        if (bus.dout !== 16'h0001) begin
            errors++;
            $display("FAIL discard_prefixed got dout=%h want 0001", bus.dout);
        end
    endtask

    task automatic test_hold_err();
        drive(1, 1, 0, 16'hABCD, 0, 0);
        drive(1, 0, 4, 0, 0, 0);
        checks++;
        if (bus.dout !== 16'hABCD || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_hold got dout=%h v=%b want ABCD v=0", bus.dout, bus.dout_valid);
        end
        drive(1, 1, 11, 0, 6'h3F, 0);
        checks++;
        if (bus.dout !== 16'hABCD || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_src got dout=%h v=%b want ABCD v=1", bus.dout, bus.dout_valid);
        end
        drive(1, 1, 13, 16'hFFFF, 6'h3F, 0);
        checks++;
        if (bus.dout !== 16'h0 || bus.dout_valid !== 1'b1 || bus.src_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal got dout=%h v=%b e=%b want 0000 v=1 e=1", bus.dout, bus.dout_valid, bus.src_err);
        end
        drive(1, 1, 2, 0, 0, 0);
        checks++;
        if (bus.dout !== 16'h0001 || bus.src_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got dout=%h e=%b want 0001 e=1", bus.dout, bus.src_err);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 1, 0, 0, 6'h2B, 1);
        #3;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({bus.dout, bus.dout_valid, bus.prefix_pending, bus.src_err} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset got dout=%h v=%b p=%b e=%b want all 0", bus.dout, bus.dout_valid, bus.prefix_pending, bus.src_err);
        end
        #1;
        rst_n = 1;
        drive(1, 1, 10, 0, 6'h05, 0);
        checks++;
        if (bus.dout !== 16'h0005 || bus.dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_prefixed got dout=%h v=%b want 0005 v=1", bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(7) != 0, $urandom_range(5) != 0, ($urandom_range(19) == 0) ? $urandom_range(15) : $urandom_range(11),
                  $urandom, $urandom_range(63), $urandom_range(2) == 0);
            checks++;
            if (bus.dout !== 16'(m_dout) || bus.dout_valid !== m_valid || bus.prefix_pending !== m_pend || bus.src_err !== m_err) begin
                errors++;
                $display("FAIL random%0d got dout=%h v=%b p=%b e=%b want %h v=%b p=%b e=%b", i, bus.dout, bus.dout_valid,
                         bus.prefix_pending, bus.src_err, 16'(m_dout), m_valid, m_pend, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_constants();
        test_prefix_chain();
        test_stall();
        test_prefix_discard();
        test_hold_err();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
